// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and default widths for the two-requester data memory arbiter.
package data_memory_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_LOCK_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester and memory-side signals of the data memory arbiter.
interface data_memory_arbiter_if
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              req0, req1;
    logic              we0, we1;
    logic              lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_out;

    // Requesters plus the memory array.
    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1, mem_out,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_write, mem_address, mem_data
    );

    // The arbiter itself.
    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1, mem_out,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_write, mem_address, mem_data
    );

endinterface

// File: rtl/data_memory_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU (requester 0) and the loader/DMA (requester 1).
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                 clock,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = (LOCK_MAX + 1 > 2) ? $clog2(LOCK_MAX + 1) : 1;

    state_t            state, state_nxt;
    logic              last, last_nxt;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic              pick_valid, pick_winner;
    logic              stay_locked;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // State register and arbitration history.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Served-last must include this cycle's grant so two busy requesters alternate.
    always_comb begin
        last_nxt = last;
        if (bus.gnt0) begin
            last_nxt = 1'b0;
        end else if (bus.gnt1) begin
            last_nxt = 1'b1;
        end
    end

    rr_pick2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_nxt),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Next-state: bounded lock extension first, otherwise round-robin.
    always_comb begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
        stay_locked  = ((state == SERVE0) && bus.req0 && bus.lock0) ||
                       ((state == SERVE1) && bus.req1 && bus.lock1);
        if (stay_locked && (lock_cnt < CNT_W'(LOCK_MAX - 1))) begin
            state_nxt    = state;
            lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end else if (pick_valid) begin
            state_nxt = pick_winner ? SERVE1 : SERVE0;
        end
    end

    // Grant and memory bus; a reset cycle forces idle values so in-flight writes are dropped.
    always_comb begin
        bus.gnt0        = 1'b0;
        bus.gnt1        = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = {ADDR_W{1'b0}};
        bus.mem_data    = {DATA_W{1'b0}};
        if (reset) begin
            case (state)
                SERVE0: begin
                    bus.gnt0        = bus.req0;
                    bus.mem_address = bus.addr0;
                    bus.mem_data    = bus.wdata0;
                    bus.mem_write   = bus.we0 & bus.req0;
                end
                SERVE1: begin
                    bus.gnt1        = bus.req1;
                    bus.mem_address = bus.addr1;
                    bus.mem_data    = bus.wdata1;
                    bus.mem_write   = bus.we1 & bus.req1;
                end
                default: begin
                end
            endcase
        end
    end

    // Read return path: capture memory data at the close of a granted read.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= bus.gnt0 & ~bus.we0;
            rvalid1_q <= bus.gnt1 & ~bus.we1;
            if (bus.gnt0 && !bus.we0) begin
                rdata0_q <= bus.mem_out;
            end
            if (bus.gnt1 && !bus.we1) begin
                rdata1_q <= bus.mem_out;
            end
        end
    end

    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural single-port memory.
module tb_data_memory_arbiter;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    data_memory_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    // Async read, write on rising edge; preload port used only while the arbiter is held in reset.
    always @(posedge clock) begin
        if (bus.mem_write) begin
            mem[bus.mem_address] <= bus.mem_data;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    assign bus.mem_out = mem[bus.mem_address];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.we0 = 1'b0;   bus.we1 = 1'b0;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        bus.addr0 = 8'd0; bus.addr1 = 8'd0;
        bus.wdata0 = 8'd0; bus.wdata1 = 8'd0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd5; bus.wdata0 = 8'd1;
        tick();
        sample();
        n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0: got %b exp 0", bus.gnt0); end
        n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %b exp 0", bus.mem_write); end
        n_checks++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 00", {bus.rvalid0, bus.rvalid1}); end
        n_checks++; if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0000", {bus.rdata0, bus.rdata1}); end
        idle_inputs();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        bus.req0 = 1'b1; bus.addr0 = 8'd100;
        sample();
        n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL rd_gnt0_c0: got %b exp 0", bus.gnt0); end
        tick();
        sample();
        n_checks++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rd_gnt0_c1: got %b exp 1", bus.gnt0); end
        n_checks++; if (bus.mem_address !== 8'd100) begin n_fail++; $display("FAIL rd_addr_c1: got %0d exp 100", bus.mem_address); end
        n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL rd_write_c1: got %b exp 0", bus.mem_write); end
        tick();
        bus.req0 = 1'b0;
        sample();
        n_checks++; if (bus.rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid0_c2: got %b exp 1", bus.rvalid0); end
        n_checks++; if (bus.rdata0 !== 8'd10) begin n_fail++; $display("FAIL rd_rdata0_c2: got %0d exp 10", bus.rdata0); end
        n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL rd_gnt0_c2: got %b exp 0", bus.gnt0); end
        tick();
        sample();
        n_checks++; if (bus.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid0_c3: got %b exp 0", bus.rvalid0); end
        n_checks++; if (bus.rdata0 !== 8'd10) begin n_fail++; $display("FAIL rd_rdata0_hold: got %0d exp 10", bus.rdata0); end
    endtask

    task automatic test_alternate();
        logic exp_g0;
        apply_reset();
        bus.req0 = 1'b1; bus.addr0 = 8'd100;
        bus.req1 = 1'b1; bus.addr1 = 8'd101;
        for (int c = 1; c <= 4; c++) begin
            tick();
            sample();
            exp_g0 = ((c % 2) == 1);
            n_checks++; if ({bus.gnt0, bus.gnt1} !== {exp_g0, ~exp_g0}) begin n_fail++; $display("FAIL alt_gnt_c%0d: got %b exp %b", c, {bus.gnt0, bus.gnt1}, {exp_g0, ~exp_g0}); end
            if (c >= 2) begin
                n_checks++; if ({bus.rvalid0, bus.rvalid1} !== {~exp_g0, exp_g0 && (c >= 3)}) begin n_fail++; $display("FAIL alt_rvalid_c%0d: got %b exp %b", c, {bus.rvalid0, bus.rvalid1}, {~exp_g0, exp_g0 && (c >= 3)}); end
            end
            if (c >= 3) begin
                n_checks++; if ({bus.rdata0, bus.rdata1} !== {8'd10, 8'd7}) begin n_fail++; $display("FAIL alt_rdata_c%0d: got %h exp 0a07", c, {bus.rdata0, bus.rdata1}); end
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock();
        apply_reset();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 8'd102; bus.wdata1 = 8'd75;
        tick();
        bus.req0 = 1'b1; bus.addr0 = 8'd102;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            sample();
            n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin n_fail++; $display("FAIL lock_gnt_c%0d: got %b exp 01", c, {bus.gnt0, bus.gnt1}); end
            n_checks++; if ({bus.mem_write, bus.mem_address, bus.mem_data} !== {1'b1, 8'd102, 8'd75}) begin n_fail++; $display("FAIL lock_bus_c%0d: got %h exp %h", c, {bus.mem_write, bus.mem_address, bus.mem_data}, {1'b1, 8'd102, 8'd75}); end
        end
        tick();
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0;
        sample();
        n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_fail++; $display("FAIL lock_gnt_c5: got %b exp 10", {bus.gnt0, bus.gnt1}); end
        n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL lock_write_c5: got %b exp 0", bus.mem_write); end
        tick();
        bus.req0 = 1'b0;
        sample();
        n_checks++; if (bus.rvalid0 !== 1'b1) begin n_fail++; $display("FAIL lock_rvalid0: got %b exp 1", bus.rvalid0); end
        n_checks++; if (bus.rdata0 !== 8'd75) begin n_fail++; $display("FAIL lock_rdata0: got %0d exp 75", bus.rdata0); end
        idle_inputs();
        tick();
    endtask

    task automatic test_drop();
        apply_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd104; bus.wdata0 = 8'd99;
        tick();
        bus.req0 = 1'b0;
        sample();
        n_checks++; if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL drop_gnt0: got %b exp 0", bus.gnt0); end
        n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL drop_write: got %b exp 0", bus.mem_write); end
        tick();
        sample();
        n_checks++; if (mem[104] !== 8'd33) begin n_fail++; $display("FAIL drop_mem104: got %0d exp 33", mem[104]); end
        n_checks++; if (bus.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL drop_rvalid0: got %b exp 0", bus.rvalid0); end
        idle_inputs();
    endtask

    task automatic test_reset_during_write();
        apply_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd103; bus.wdata0 = 8'd9;
        tick();
        sample();
        n_checks++; if ({bus.gnt0, bus.mem_write} !== 2'b11) begin n_fail++; $display("FAIL rw_pre_reset: got %b exp 11", {bus.gnt0, bus.mem_write}); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if ({bus.gnt0, bus.gnt1, bus.mem_write} !== 3'b000) begin n_fail++; $display("FAIL rw_forced_idle: got %b exp 000", {bus.gnt0, bus.gnt1, bus.mem_write}); end
        n_checks++; if ({bus.mem_address, bus.mem_data} !== 16'h0000) begin n_fail++; $display("FAIL rw_forced_bus: got %h exp 0000", {bus.mem_address, bus.mem_data}); end
        tick();
        reset = 1'b1;
        bus.we0 = 1'b0; bus.addr0 = 8'd100;
        bus.req1 = 1'b1; bus.addr1 = 8'd101;
        sample();
        n_checks++; if (mem[103] !== 8'd55) begin n_fail++; $display("FAIL rw_mem103: got %0d exp 55", mem[103]); end
        n_checks++; if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0000) begin n_fail++; $display("FAIL rw_after_reset: got %b exp 0000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}); end
        tick();
        sample();
        n_checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_fail++; $display("FAIL rw_tie_after_reset: got %b exp 10", {bus.gnt0, bus.gnt1}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_idle();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            sample();
            n_checks++; if ({bus.mem_write, bus.mem_address, bus.mem_data, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 21'd0) begin n_fail++; $display("FAIL idle_c%0d: got %h exp 0", c, {bus.mem_write, bus.mem_address, bus.mem_data, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        pl_we = 1'b0; pl_addr = 8'd0; pl_data = 8'd0;
        idle_inputs();
        preload(8'd100, 8'd10);
        preload(8'd101, 8'd7);
        preload(8'd102, 8'd0);
        preload(8'd103, 8'd55);
        preload(8'd104, 8'd33);
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_drop();
        test_reset_during_write();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester arbiter sharing the single-port 8-bit data memory (async read, write on rising clock edge) between the CPU datapath (requester 0) and the memory loader/DMA engine (requester 1). Registered round-robin grant, optional bounded lock for multi-word bursts, one access per cycle, read data registered back to the winning requester.

## Interface
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- LOCK_MAX, 4, max consecutive grants to one locked requester (≥1).
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on rising edge of clock).
- req0 / req1  in  1  access request; must hold stable with addr/we/wdata until gnt seen.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  ask to keep grant on next cycle (burst).
- addr0 / addr1  in  ADDR_W  access address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  access performed this cycle.
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN valid.
- rdata0 / rdata1  out  DATA_W  registered read data, held until next read.
- mem_write  out  1  to memory write enable.
- mem_address  out  ADDR_W  to memory address.
- mem_data  out  DATA_W  to memory write data.
- mem_out  in  DATA_W  from memory combinational read data.

## Operation
- FSM states: IDLE, SERVE0, SERVE1. Registers: state, last (last served, 0/1), lock_cnt (ceil(log2(LOCK_MAX+1)) bits).
- In SERVEx: gntx = reqx; mem bus muxed from requester x; mem_write = wex & reqx. Requester x absent (reqx=0) in SERVEx → access cancelled: gnt 0, no write, no rvalid.
- In IDLE: gnt0=gnt1=0; mem_write=0, mem_address=0, mem_data=0.
- Next-state pick (from any state): if current SERVEx, reqx, lockx, and lock_cnt < LOCK_MAX−1 → stay SERVEx, lock_cnt+1. Else round-robin: both requesting → the one ≠ last; one requesting → that one; none → IDLE. lock_cnt cleared on any change of owner or when not locked.
- last updates to x on every cycle SERVEx completes with gntx=1.
- Read: on a granted read, mem_out captured into rdatax at the closing edge; rvalidx=1 during the following cycle only. rdata of the other requester unchanged.
- Write: memory commits at closing edge of the gnt cycle; no rvalid.
- Reset (reset=0 at an edge): state=IDLE, last=1 (requester 0 wins first tie), lock_cnt=0, rdata0/1=0, rvalid0/1=0. Outputs during a reset cycle are forced to idle values: mem_write=0, gnt0/1=0, so an access in flight when reset asserts is dropped (no write commits).

## Timing
- Latency from IDLE: req at cycle 0 → gnt cycle 1 → rvalid/rdata cycle 2.
- Continuous requester: one access per cycle; two continuous requesters alternate 0,1,0,1 absent lock.
- Lock: at most LOCK_MAX consecutive grants to one requester while the other waits; the other is then granted next cycle.
- Grant and mem bus outputs combinational from state and requester inputs; rvalid/rdata registered.
- Simultaneous rvalid for one requester and gnt for the other allowed in the same cycle.

## Structure
- Shared package: state enum (IDLE, SERVE0, SERVE1), default ADDR_W/DATA_W.
- Sub-module rr_pick2: combinational two-way round-robin picker (req0, req1, last → valid, winner); instantiated once for next-state.

## Test plan
- Memory preloaded 100=10, 101=7; req0 read addr 100 from IDLE → gnt0 cycle 1, rvalid0 cycle 2 with rdata0=10.
- req0 and req1 reads of 100/101 asserted together, held → grants 0,1,0,1; rdata0=10, rdata1=7.
- req1 write 102←75 with lock1=1 held, req0 waiting, LOCK_MAX=4 → gnt1 four cycles, then gnt0; read of 102 returns 75.
- reqx dropped during its SERVEx cycle with we=1 → gnt 0, mem_write 0, memory unchanged.
- reset=0 asserted during a granted write of 103←9 → mem_write 0 that cycle, 103 keeps old value, all outputs 0, next tie goes to requester 0.
- Idle with no requests → mem_write/address/data 0, gnt/rvalid 0 every cycle.
